c1541_gcr_track_ctrl: RTL and testbench
=======================================

Name: c1541_gcr_track_ctrl

Overview:
Sequences whole-track transfers between the SD image and the direct-GCR track buffer of the 1541 drive.
- Watches the head half-track, debounces stepper motion, and writes back the current track if dirty.
- Then loads the new track as consecutive 512-byte SD blocks, holding the GCR datapath in `busy` throughout.
- Sits between the drive core (stepper/motor/GCR write strobe) and the MiSTer SD block handshake.

Parameters:
- HT_MAX, 84, number of half-tracks in image; `ht` values ≥ HT_MAX are clamped to HT_MAX-1.
- BLK_PER_TRK, 16, 512-byte SD blocks per track slot (8 KB buffer).
- SETTLE, 4096, clk cycles `ht` must stay unchanged before a transfer starts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- img_mounted  in  1  one-cycle pulse: new image mounted
- img_readonly  in  1  image is write-protected
- ht  in  7  current head half-track from stepper
- mtr  in  1  spindle motor on
- gcr_we  in  1  write strobe from the GCR datapath (one pulse per written bit)
- busy  out  1  track buffer owned by SD side; GCR datapath frozen
- cur_ht  out  7  half-track currently held in buffer
- trk_valid  out  1  buffer holds a loaded track
- sd_lba  out  32  block address = cur_slot*BLK_PER_TRK + blk
- sd_rd  out  1  block read request
- sd_wr  out  1  block write request
- sd_ack  in  1  SD side acknowledges/transfers the current block
- sd_blk  out  4  block index within track (to upper buffer address bits)

Behaviour:
- Reset values: busy=1, trk_valid=0, cur_ht=0, sd_rd=0, sd_wr=0, sd_lba=0, sd_blk=0, dirty=0, state=IDLE.
- Reset mid-transfer: immediate IDLE with requests dropped; the current block is abandoned and the buffer content is undefined.
- dirty:
  - Set on any `gcr_we` while trk_valid=1, busy=0 and img_readonly=0.
  - Cleared at completion of FLUSH, on img_mounted, and on reset.
- States:
  - IDLE: if (ht≠cur_ht or trk_valid=0) and an image is mounted -> SETTLE (busy stays as is); otherwise busy=0.
  - SETTLE: counter counts SETTLE cycles, restarting on any `ht` change. On expiry: dirty -> FLUSH_REQ, else LOAD_REQ. Expiry with ht==cur_ht and trk_valid=1 -> IDLE. busy=1 from SETTLE exit onward.
  - FLUSH_REQ: sd_lba from cur_ht slot; sd_wr=1 until sd_ack=1 -> FLUSH_WAIT (sd_wr drops the cycle after ack seen).
  - FLUSH_WAIT: on sd_ack falling edge, blk+1. If blk was BLK_PER_TRK-1 -> clear dirty, blk=0, LOAD_REQ; else FLUSH_REQ.
  - LOAD_REQ/LOAD_WAIT: identical handshake with sd_rd, using the slot of the latched target ht. After the last block: cur_ht=target, trk_valid=1, blk=0 -> IDLE; busy=0 the following cycle.
- Target ht is latched on SETTLE exit. Head motion during FLUSH/LOAD is ignored until IDLE, then re-evaluated.
- sd_rd and sd_wr are never both 1. At most one request is outstanding.
- img_mounted during a transfer: finish the current block handshake, then trk_valid=0, dirty=0 -> IDLE (forces a reload).
- img_readonly=1: FLUSH is never entered.
- sd_lba arithmetic: 32-bit, slot*BLK_PER_TRK+blk with no overflow check.

Optional Feature:
- C1541_GCR_IDLE_FLUSH_EN defined: if dirty=1 and mtr=0 for SETTLE cycles in IDLE, run FLUSH then return to IDLE without LOAD; trk_valid stays 1.
- Undefined: write-back occurs only on track change.

Decomposition:
- Package c1541_gcr_pkg:
  - state enum (IDLE, SETTLE, FLUSH_REQ, FLUSH_WAIT, LOAD_REQ, LOAD_WAIT)
  - HT_W=7
  - BLK_BYTES=512
- Sub-module c1541_gcr_blk_seq: generic per-block req/ack sequencer (start, dir, count -> req, blk, done), instantiated once and shared by FLUSH and LOAD.

Test Plan:
- Reset, then ht=36 held with SETTLE=16 -> 16 reads, LBA 576..591, then trk_valid=1, cur_ht=36, busy=0.
- From cur_ht=36, issue 3 gcr_we pulses, then ht=38 -> 16 writes at LBA 576..591 followed by 16 reads at LBA 608..623, with no read before the last write ack falls.
- ht toggling 36/37 every 10 cycles with SETTLE=16 -> no SD request issued and busy stays 0 until ht is stable for 16 cycles.
- img_readonly=1, gcr_we pulses, then ht change -> no sd_wr ever asserted and the load proceeds directly.
- img_mounted pulse at block 5 of a load -> block 5 completes, then trk_valid=0 and a full reload of the same ht starts from LBA offset 0.
- Reset asserted while sd_rd=1 -> next cycle sd_rd=0, busy=1, trk_valid=0.

Source files
------------

// File: rtl/c1541_gcr_pkg.sv
// Shared types and constants for the 1541 GCR track-buffer controller.
// The idle write-back option is enabled by defining C1541_GCR_IDLE_FLUSH_EN.
package c1541_gcr_pkg;

    localparam int HT_W      = 7;
    localparam int BLK_BYTES = 512;
    localparam int BLK_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FLUSH_REQ,
        S_FLUSH_WAIT,
        S_LOAD_REQ,
        S_LOAD_WAIT
    } state_e;

    // Half-tracks beyond the image end map onto the last half-track slot.
    function automatic logic [HT_W-1:0] clamp_ht(input logic [HT_W-1:0] ht, input int ht_max);
        if (int'(ht) >= ht_max) return HT_W'(ht_max - 1);
        return ht;
    endfunction

endpackage

// File: rtl/c1541_gcr_track_ctrl_blk_seq.sv
// Generic multi-block SD req/ack sequencer: one request per block, next block
// after the ack falls, optional early stop once the current block completes.
module c1541_gcr_blk_seq
    import c1541_gcr_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             dir_wr_i,
    input  logic [BLK_W:0]   count_i,
    input  logic             stop_i,
    input  logic             ack_i,
    output logic             rd_o,
    output logic             wr_o,
    output logic [BLK_W-1:0] blk_o,
    output logic             step_o,
    output logic             done_o
);

    logic             active_q, active_d;
    logic             req_q, req_d;
    logic             dir_q, dir_d;
    logic             ack_q;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             fall;
    logic             last;

    always_comb begin
        fall   = active_q && !req_q && ack_q && !ack_i;
        last   = ({1'b0, blk_q} + 1'b1) == count_i;
        step_o = fall;
        done_o = fall && (last || stop_i);

        active_d = active_q;
        req_d    = req_q;
        dir_d    = dir_q;
        blk_d    = blk_q;

        if (fall) begin
            if (last || stop_i) begin
                active_d = 1'b0;
                blk_d    = '0;
            end else begin
                blk_d = blk_q + 1'b1;
                req_d = 1'b1;
            end
        end
        // The request drops the cycle after the ack is seen.
        if (req_q && ack_i) req_d = 1'b0;
        if (start_i) begin
            active_d = 1'b1;
            req_d    = 1'b1;
            blk_d    = '0;
            dir_d    = dir_wr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            req_q    <= 1'b0;
            dir_q    <= 1'b0;
            ack_q    <= 1'b0;
            blk_q    <= '0;
        end else begin
            active_q <= active_d;
            req_q    <= req_d;
            dir_q    <= dir_d;
            ack_q    <= ack_i;
            blk_q    <= blk_d;
        end
    end

    assign rd_o  = req_q && !dir_q;
    assign wr_o  = req_q && dir_q;
    assign blk_o = blk_q;

endmodule

// File: rtl/c1541_gcr_track_ctrl.sv
// Whole-track SD <-> GCR buffer sequencer: settle, optional write-back, reload.
// Define C1541_GCR_IDLE_FLUSH_EN to also write back a dirty track once the motor stops.
module c1541_gcr_track_ctrl
    import c1541_gcr_pkg::*;
#(
    parameter int HT_MAX      = 84,
    parameter int BLK_PER_TRK = 16,
    parameter int SETTLE      = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            img_mounted,
    input  logic            img_readonly,
    input  logic [HT_W-1:0] ht,
    input  logic            mtr,
    input  logic            gcr_we,
    output logic            busy,
    output logic [HT_W-1:0] cur_ht,
    output logic            trk_valid,
    output logic [31:0]     sd_lba,
    output logic            sd_rd,
    output logic            sd_wr,
    input  logic            sd_ack,
    output logic [3:0]      sd_blk
);

`ifdef C1541_GCR_IDLE_FLUSH_EN
    localparam bit IDLE_FLUSH = 1'b1;
`else
    localparam bit IDLE_FLUSH = 1'b0;
`endif

    localparam int              CNT_W    = $clog2(SETTLE) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            trk_valid_q, trk_valid_d;
    logic            dirty_q, dirty_d;
    logic            mounted_q, mounted_d;
    logic            pend_mount_q, pend_mount_d;
    logic            idle_flush_q, idle_flush_d;
    logic [HT_W-1:0] cur_ht_q, cur_ht_d;
    logic [HT_W-1:0] target_q, target_d;
    logic [HT_W-1:0] ht_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            ht_c;
    logic [HT_W-1:0] ht_cl;
    logic            need_load;
    logic            mount_now;
    logic            seq_start, seq_dir_wr, seq_step, seq_done;
    logic [HT_W-1:0] slot;

    assign ht_cl     = clamp_ht(ht, HT_MAX);
    assign ht_c      = (ht_cl != ht_prev_q);
    assign need_load = mounted_q && (!trk_valid_q || ht_cl != cur_ht_q);
    assign mount_now = pend_mount_q || img_mounted;

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        trk_valid_d  = trk_valid_q;
        dirty_d      = dirty_q;
        mounted_d    = mounted_q;
        pend_mount_d = pend_mount_q;
        idle_flush_d = idle_flush_q;
        cur_ht_d     = cur_ht_q;
        target_d     = target_q;
        cnt_d        = cnt_q;
        seq_start    = 1'b0;
        seq_dir_wr   = 1'b0;

        if (gcr_we && trk_valid_q && !busy_q && !img_readonly) dirty_d = 1'b1;
        if (img_mounted) begin
            dirty_d   = 1'b0;
            mounted_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (img_mounted) trk_valid_d = 1'b0;
                if (need_load) begin
                    state_d = S_SETTLE;
                end else begin
                    busy_d = 1'b0;
                    if (IDLE_FLUSH && dirty_q && !mtr && !img_readonly && trk_valid_q && !img_mounted) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d      = S_FLUSH_REQ;
                            busy_d       = 1'b1;
                            idle_flush_d = 1'b1;
                            seq_start    = 1'b1;
                            seq_dir_wr   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_SETTLE: begin
                if (img_mounted) trk_valid_d = 1'b0;
                if (ht_c) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (trk_valid_q && !img_mounted && ht_cl == cur_ht_q) begin
                        state_d = S_IDLE;
                    end else begin
                        busy_d    = 1'b1;
                        target_d  = ht_cl;
                        seq_start = 1'b1;
                        if (dirty_q && !img_readonly && !img_mounted) begin
                            state_d    = S_FLUSH_REQ;
                            seq_dir_wr = 1'b1;
                        end else begin
                            state_d = S_LOAD_REQ;
                        end
                    end
                end
            end
            S_FLUSH_REQ: begin
                pend_mount_d = mount_now;
                if (sd_ack) state_d = S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
                pend_mount_d = mount_now;
                if (seq_done) begin
                    dirty_d      = 1'b0;
                    pend_mount_d = 1'b0;
                    idle_flush_d = 1'b0;
                    if (mount_now) begin
                        trk_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else if (idle_flush_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_LOAD_REQ;
                        seq_start = 1'b1;
                    end
                end else if (seq_step) begin
                    state_d = S_FLUSH_REQ;
                end
            end
            S_LOAD_REQ: begin
                pend_mount_d = mount_now;
                if (sd_ack) state_d = S_LOAD_WAIT;
            end
            S_LOAD_WAIT: begin
                pend_mount_d = mount_now;
                if (seq_done) begin
                    pend_mount_d = 1'b0;
                    state_d      = S_IDLE;
                    if (mount_now) begin
                        trk_valid_d = 1'b0;
                    end else begin
                        cur_ht_d    = target_q;
                        trk_valid_d = 1'b1;
                    end
                end else if (seq_step) begin
                    state_d = S_LOAD_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b1;
            trk_valid_q  <= 1'b0;
            dirty_q      <= 1'b0;
            mounted_q    <= 1'b0;
            pend_mount_q <= 1'b0;
            idle_flush_q <= 1'b0;
            cur_ht_q     <= '0;
            target_q     <= '0;
            ht_prev_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            trk_valid_q  <= trk_valid_d;
            dirty_q      <= dirty_d;
            mounted_q    <= mounted_d;
            pend_mount_q <= pend_mount_d;
            idle_flush_q <= idle_flush_d;
            cur_ht_q     <= cur_ht_d;
            target_q     <= target_d;
            ht_prev_q    <= ht_cl;
            cnt_q        <= cnt_d;
        end
    end

    c1541_gcr_blk_seq u_seq (
        .clk      (clk),
        .reset    (reset),
        .start_i  (seq_start),
        .dir_wr_i (seq_dir_wr),
        .count_i  ((BLK_W + 1)'(BLK_PER_TRK)),
        .stop_i   (mount_now),
        .ack_i    (sd_ack),
        .rd_o     (sd_rd),
        .wr_o     (sd_wr),
        .blk_o    (sd_blk),
        .step_o   (seq_step),
        .done_o   (seq_done)
    );

    // Loads address the incoming track; everything else addresses the resident one.
    assign slot      = (state_q == S_LOAD_REQ || state_q == S_LOAD_WAIT) ? target_q : cur_ht_q;
    assign sd_lba    = 32'(slot) * 32'(BLK_PER_TRK) + 32'(sd_blk);
    assign busy      = busy_q;
    assign cur_ht    = cur_ht_q;
    assign trk_valid = trk_valid_q;

endmodule

// File: tb/tb_c1541_gcr_track_ctrl.sv
// Directed bench for c1541_gcr_track_ctrl with a small SD block responder.
module tb_c1541_gcr_track_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic        img_readonly = 1'b0;
    logic [6:0]  ht = '0;
    logic        mtr = 1'b1;
    logic        gcr_we = 1'b0;
    logic        sd_ack = 1'b0;
    logic        busy, trk_valid, sd_rd, sd_wr;
    logic [6:0]  cur_ht;
    logic [31:0] sd_lba;
    logic [3:0]  sd_blk;

    int  checks = 0;
    int  errors = 0;
    int  lba_q[$];
    bit  wr_q[$];
    time t_q[$];
    int  ack_cnt = 0;
    bit  cur_wr = 1'b0;
    time last_wr_fall = 0;
    bit  req_seen, busy_seen, both_seen, wr_seen;

    c1541_gcr_track_ctrl #(.HT_MAX(84), .BLK_PER_TRK(16), .SETTLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .ht           (ht),
        .mtr          (mtr),
        .gcr_we       (gcr_we),
        .busy         (busy),
        .cur_ht       (cur_ht),
        .trk_valid    (trk_valid),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_blk       (sd_blk)
    );

    always #5 clk = ~clk;

    // SD side: log each request, hold ack for two cycles, then release it.
    always @(negedge clk) begin
        if (sd_rd && sd_wr) both_seen = 1'b1;
        if (sd_rd || sd_wr) req_seen = 1'b1;
        if (sd_wr) wr_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                sd_ack = 1'b0;
                if (cur_wr) last_wr_fall = $time;
            end
        end else if ((sd_rd || sd_wr) && !sd_ack) begin
            lba_q.push_back(int'(sd_lba));
            wr_q.push_back(sd_wr);
            t_q.push_back($time);
            cur_wr  = sd_wr;
            sd_ack  = 1'b1;
            ack_cnt = 2;
        end
    end

    task automatic clear_log();
        lba_q.delete();
        wr_q.delete();
        t_q.delete();
        req_seen  = 1'b0;
        busy_seen = 1'b0;
        both_seen = 1'b0;
        wr_seen   = 1'b0;
    endtask

    task automatic pulse_mount();
        @(negedge clk); #1 img_mounted = 1'b1;
        @(negedge clk); #1 img_mounted = 1'b0;
    endtask

    task automatic pulse_we3();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 gcr_we = 1'b1;
            @(negedge clk); #1 gcr_we = 1'b0;
        end
    endtask

    task automatic wait_ready(input logic [6:0] exp_ht, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (trk_valid === 1'b1 && busy === 1'b0 && cur_ht === exp_ht) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
        checks++; if (trk_valid !== 1'b0) begin errors++; $display("FAIL reset_trk_valid got=%b exp=0", trk_valid); end
        checks++; if (cur_ht !== 7'd0) begin errors++; $display("FAIL reset_cur_ht got=%0d exp=0", cur_ht); end
        checks++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin errors++; $display("FAIL reset_req got rd=%b wr=%b exp 0/0", sd_rd, sd_wr); end
        checks++; if (sd_lba !== 32'd0) begin errors++; $display("FAIL reset_lba got=%0d exp=0", sd_lba); end
        checks++; if (sd_blk !== 4'd0) begin errors++; $display("FAIL reset_blk got=%0d exp=0", sd_blk); end
        reset = 1'b0;
        clear_log();
        repeat (5) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomount_busy got=%b exp=0", busy); end
        checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL nomount_req got=%b exp=0", req_seen); end
    endtask

    task automatic test_load();
        bit ok;
        clear_log();
        ht = 7'd36;
        pulse_mount();
        wait_ready(7'd36, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL load_done timeout got=%b exp=1", ok); end
        checks++; if (lba_q.size() != 16) begin errors++; $display("FAIL load_count got=%0d exp=16", lba_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            checks++;
            if (lba_q[i] != 576 + i || wr_q[i] !== 1'b0) begin
                errors++; $display("FAIL load_blk%0d got lba=%0d wr=%b exp lba=%0d wr=0", i, lba_q[i], wr_q[i], 576 + i);
            end
        end
        checks++; if (sd_blk !== 4'd0) begin errors++; $display("FAIL load_blk_rst got=%0d exp=0", sd_blk); end
    endtask

    task automatic test_toggle();
        clear_log();
        for (int i = 0; i < 8; i++) begin
            ht = (i % 2 == 0) ? 7'd37 : 7'd36;
            repeat (10) @(negedge clk);
            #1;
        end
        checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL toggle_req got=%b exp=0", req_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL toggle_busy got=%b exp=0", busy_seen); end
        repeat (40) @(negedge clk);
        #1;
        checks++; if (req_seen !== 1'b0 || busy_seen !== 1'b0) begin errors++; $display("FAIL toggle_settle got req=%b busy=%b exp 0/0", req_seen, busy_seen); end
        checks++; if (cur_ht !== 7'd36 || trk_valid !== 1'b1) begin errors++; $display("FAIL toggle_track got ht=%0d v=%b exp 36/1", cur_ht, trk_valid); end
    endtask

    task automatic test_flush();
        bit ok;
        pulse_we3();
        clear_log();
        ht = 7'd38;
        wait_ready(7'd38, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_done timeout got=%b exp=1", ok); end
        checks++; if (lba_q.size() != 32) begin errors++; $display("FAIL flush_count got=%0d exp=32", lba_q.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (lba_q[i] != 576 + i || wr_q[i] !== 1'b1) begin
                    errors++; $display("FAIL flush_wr%0d got lba=%0d wr=%b exp lba=%0d wr=1", i, lba_q[i], wr_q[i], 576 + i);
                end
                checks++;
                if (lba_q[16 + i] != 608 + i || wr_q[16 + i] !== 1'b0) begin
                    errors++; $display("FAIL flush_rd%0d got lba=%0d wr=%b exp lba=%0d wr=0", i, lba_q[16 + i], wr_q[16 + i], 608 + i);
                end
            end
            checks++;
            if (t_q[16] <= last_wr_fall) begin
                errors++; $display("FAIL flush_order first_rd=%0t last_wr_fall=%0t exp rd later", t_q[16], last_wr_fall);
            end
        end
        checks++; if (both_seen !== 1'b0) begin errors++; $display("FAIL rd_wr_both got=%b exp=0", both_seen); end
    endtask

    task automatic test_readonly();
        bit ok;
        img_readonly = 1'b1;
        pulse_we3();
        clear_log();
        ht = 7'd40;
        wait_ready(7'd40, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ro_done timeout got=%b exp=1", ok); end
        checks++; if (wr_seen !== 1'b0) begin errors++; $display("FAIL ro_write got=%b exp=0", wr_seen); end
        checks++; if (lba_q.size() != 16) begin errors++; $display("FAIL ro_count got=%0d exp=16", lba_q.size()); end
        else begin
            checks++;
            if (lba_q[0] != 640 || lba_q[15] != 655) begin
                errors++; $display("FAIL ro_lba got first=%0d last=%0d exp 640/655", lba_q[0], lba_q[15]);
            end
        end
        img_readonly = 1'b0;
    endtask

    task automatic test_mount_mid_load();
        bit ok;
        clear_log();
        ht = 7'd42;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #1;
            if (lba_q.size() == 6) ok = 1'b1;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mnt_blk5 timeout got=%b exp=1", ok); end
        img_mounted = 1'b1;
        @(negedge clk); #1 img_mounted = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (trk_valid === 1'b0) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mnt_invalidate timeout got=%b exp=1", ok); end
        checks++; if (lba_q.size() != 6) begin errors++; $display("FAIL mnt_abort_count got=%0d exp=6", lba_q.size()); end
        checks++; if (lba_q[5] != 677) begin errors++; $display("FAIL mnt_blk5_lba got=%0d exp=677", lba_q[5]); end
        checks++; if (cur_ht !== 7'd40) begin errors++; $display("FAIL mnt_cur_ht got=%0d exp=40", cur_ht); end
        wait_ready(7'd42, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mnt_reload timeout got=%b exp=1", ok); end
        checks++; if (lba_q.size() != 22) begin errors++; $display("FAIL mnt_reload_count got=%0d exp=22", lba_q.size()); end
        else for (int i = 0; i < 16; i++) begin
            checks++;
            if (lba_q[6 + i] != 672 + i || wr_q[6 + i] !== 1'b0) begin
                errors++; $display("FAIL mnt_reload%0d got lba=%0d wr=%b exp lba=%0d wr=0", i, lba_q[6 + i], wr_q[6 + i], 672 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_log();
        ht = 7'd44;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk); #1;
            if (sd_rd === 1'b1) ok = 1'b1;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_rd timeout got=%b exp=1", ok); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin errors++; $display("FAIL rstmid_req got rd=%b wr=%b exp 0/0", sd_rd, sd_wr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
        checks++; if (trk_valid !== 1'b0 || cur_ht !== 7'd0) begin errors++; $display("FAIL rstmid_trk got v=%b ht=%0d exp 0/0", trk_valid, cur_ht); end
        @(negedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_clamp();
        bit ok;
        clear_log();
        ht = 7'd100;
        pulse_mount();
        wait_ready(7'd83, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clamp_done timeout got=%b exp=1", ok); end
        checks++; if (lba_q.size() != 16) begin errors++; $display("FAIL clamp_count got=%0d exp=16", lba_q.size()); end
        else begin
            checks++;
            if (lba_q[0] != 1328 || lba_q[15] != 1343) begin
                errors++; $display("FAIL clamp_lba got first=%0d last=%0d exp 1328/1343", lba_q[0], lba_q[15]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_toggle();
        test_flush();
        test_readonly();
        test_mount_mid_load();
        test_reset_mid();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
